// File: rtl/deskew_collector.sv
// deskew_collector: realigns the skewed bottom-edge wavefront of the array into whole row vectors
module deskew_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int ROWS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din [N-1:0],
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] dout [N-1:0],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  tile_done,
    output logic                  stall
);
    localparam int CW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROWS - 1);
    logic                  adv;
    logic                  acc;
    logic [N-2:0]          vchain;
    logic [CW-1:0]         row_cnt;
    logic [DATA_WIDTH-1:0] tail [N-1:0];
    assign stall    = out_valid & ~out_ready;
    assign adv      = en & ~stall;
    assign acc      = out_valid & out_ready;
    assign out_last = out_valid & (row_cnt == LAST);
    genvar j;
    for (j = 0; j < N; j++) begin : g_lane
        if (j < N - 1) begin : g_chain
            logic [DATA_WIDTH-1:0] ch [N-1-j];
            // lane j waits N-1-j advances so it lines up with lane 0
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < N - 1 - j; i++) ch[i] <= '0;
                end else if (adv) begin
                    ch[0] <= din[j];
                    for (int i = 1; i < N - 1 - j; i++) ch[i] <= ch[i-1];
                end
            end
            assign tail[j] = ch[N-2-j];
        end else begin : g_direct
            assign tail[j] = din[j];
        end
    end
    // valid bits travel alongside lane 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vchain <= '0;
        end else if (adv) begin
            vchain[0] <= in_valid;
            for (int i = 1; i < N - 1; i++) vchain[i] <= vchain[i-1];
        end
    end
    // aligned output vector, frozen while the consumer stalls us
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) dout[i] <= '0;
        end else if (adv) begin
            for (int i = 0; i < N; i++) dout[i] <= tail[i];
        end
    end
    // an accept without a shift empties the output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_valid <= 1'b0;
        else out_valid <= adv ? vchain[N-2] : (out_ready ? 1'b0 : out_valid);
    end
    // row position within the tile and the end-of-tile pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt   <= '0;
            tile_done <= 1'b0;
        end else begin
            row_cnt   <= acc ? (row_cnt == LAST ? '0 : row_cnt + 1'b1) : row_cnt;
            tile_done <= acc & out_last;
        end
    end
endmodule

// File: tb/tb_deskew_collector.sv
// tb_deskew_collector: directed scoreboard bench for the output deskew stage
module tb_deskew_collector;
    localparam int DW = 16, N = 4, ROWS = 4;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] din [N-1:0];
    logic [DW-1:0] dout [N-1:0];
    logic out_valid, out_last, tile_done, stall;
    typedef struct { int row; int ready_at; } ent_t;
    ent_t q[$];
    int row_at [64];
    int adv_done, acc_cnt, ncmp, nfail, mode, cyc, bp_left, n_stall, n_td, n_last, n_acc;
    logic exp_td;

    always #5 clk = ~clk;

    deskew_collector #(.DATA_WIDTH(DW), .N(N), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .in_valid(in_valid),
        .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .tile_done(tile_done), .stall(stall)
    );

    function automatic logic [N*DW-1:0] row_vec(int r);
        logic [N*DW-1:0] v = '0;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(16 * r + j);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] pack_dout();
        logic [N*DW-1:0] v = '0;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = dout[j];
        return v;
    endfunction

    function automatic logic [DW-1:0] lane(int t, int j);
        if (t - j >= 0 && t - j < 64 && row_at[t-j] >= 0) return DW'(16 * row_at[t-j] + j);
        return DW'($urandom);
    endfunction

    task automatic chk(string tag, logic [N*DW-1:0] obs, logic [N*DW-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        q.delete();
        adv_done = 0;
        acc_cnt  = 0;
        exp_td   = 1'b0;
        cyc      = 0;
        foreach (row_at[i]) row_at[i] = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
    endtask

    task automatic cycle();
        logic e_ov, e_stall, e_last, acc, adv;
        e_ov      = q.size() > 0 && q[0].ready_at == adv_done;
        en        = (mode == 2) ? (cyc % 2 == 1) : 1'b1;
        out_ready = 1'b1;
        if (mode == 1 && e_ov && q[0].row == 2 && bp_left > 0) begin
            out_ready = 1'b0;
            bp_left--;
        end
        in_valid = adv_done < 64 && row_at[adv_done] >= 0;
        for (int j = 0; j < N; j++) din[j] = lane(adv_done, j);
        e_stall = e_ov & ~out_ready;
        e_last  = e_ov && (acc_cnt % ROWS == ROWS - 1);
        @(negedge clk);
        chk("out_valid", out_valid, e_ov);
        chk("stall", stall, e_stall);
        chk("out_last", out_last, e_last);
        chk("tile_done", tile_done, exp_td);
        if (e_ov) chk("dout", pack_dout(), row_vec(q[0].row));
        n_stall += int'(stall);
        n_td    += int'(tile_done);
        n_last  += int'(out_last);
        n_acc   += int'(out_valid & out_ready);
        acc    = e_ov & out_ready;
        adv    = en & ~e_stall;
        exp_td = acc & e_last;
        if (acc) begin
            void'(q.pop_front());
            acc_cnt++;
        end
        if (adv) begin
            if (in_valid) q.push_back('{row_at[adv_done], adv_done + N});
            adv_done++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ncmp = 0;
        nfail = 0;
        mode = 0;
        reset_model();
        for (int j = 0; j < N; j++) din[j] = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_tile_done", tile_done, 0);
        chk("rst_dout", pack_dout(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int r = 0; r < 8; r++) row_at[r] = r;
        n_td = 0;
        n_last = 0;
        repeat (14) cycle();
        chk("align_drained", q.size(), 0);
        chk("tile_done_count", n_td, 2);
        chk("out_last_count", n_last, 2);

        do_reset();
        mode = 1;
        bp_left = 3;
        n_stall = 0;
        for (int r = 0; r < 8; r++) row_at[r] = r;
        repeat (18) cycle();
        chk("bp_drained", q.size(), 0);
        chk("bp_stall_count", n_stall, 3);

        do_reset();
        mode = 2;
        for (int r = 0; r < 8; r++) row_at[r] = r;
        repeat (30) cycle();
        chk("gap_drained", q.size(), 0);

        do_reset();
        mode = 0;
        row_at[0] = 0;
        row_at[3] = 1;
        row_at[4] = 2;
        n_acc = 0;
        repeat (12) cycle();
        chk("bubble_drained", q.size(), 0);
        chk("bubble_accepts", n_acc, 3);

        do_reset();
        for (int r = 0; r < 8; r++) row_at[r] = r;
        repeat (6) cycle();
        out_ready = 1'b0;
        en = 1'b1;
        #1;
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_stall", stall, 1);
        rst = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_stall", stall, 0);
        chk("async_out_last", out_last, 0);
        chk("async_tile_done", tile_done, 0);
        chk("async_dout", pack_dout(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        for (int r = 0; r < 4; r++) row_at[r] = r;
        repeat (10) cycle();
        chk("post_rst_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
